demux14_tdm: RTL and testbench
==============================

# demux14_tdm

- Time-division 1-to-4 demultiplexer: the receive end of the 4:1 mux path.
- Takes a serial stream of slot beats on one input, where each beat is one selected channel in slot order 0,1,2,3.
- Rebuilds the four channel values and presents them together, registered, with a one-cycle frame-valid strobe.
- Sits downstream of the mux41 datapath and realigns to the frame on a sync marker.

## Interface
Parameters:
- W, 1, width of each channel sample in bits (1..32)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- din  input  W  incoming slot beat
- din_vld  input  1  din carries a beat this cycle
- sync  input  1  qualifies the current beat as slot 0; only meaningful when din_vld=1
- o0, o1, o2, o3  output  W  demultiplexed channel values, registered
- s1, s0  output  1 each  current expected slot index {s1,s0}
- frame_vld  output  1  one-cycle pulse when o0..o3 update
- sync_err  output  1  one-cycle pulse on a misaligned sync
- locked  output  1  high while in RUN
- err_cnt  output  8  saturating sync-error count; present only with DEMUX_ERRCNT_EN

## Operation
States: IDLE, RUN.

Reset (rst_n=0 at a clock edge):
- State goes to IDLE.
- o0..o3, {s1,s0}, shadow registers and err_cnt go to 0.
- frame_vld, sync_err and locked go to 0.
- Reset mid-frame discards the partial frame; outputs clear.

IDLE:
- Ignores all beats except one with din_vld=1 and sync=1.
- On that beat: shadow0<=din, slot<=1, state goes to RUN.

RUN, on each beat (din_vld=1):
- Beat with sync=0 at slot k: shadow_k<=din, slot<=k+1 (mod 4).
- Beat at slot 3 with sync=0:
  - o0..o2 take shadow0..2 and o3 takes din.
  - frame_vld=1 for one cycle.
  - slot wraps to 0.
- Beat at slot 0 with sync=1: normal start-of-frame, no error.
- Beat at slot 0 with sync=0: accepted as slot 0. Sync is not mandatory on every frame.
- Beat with sync=1 at slot 1..3 (misalignment):
  - sync_err=1 for one cycle.
  - Partial frame discarded; o0..o3 unchanged and no frame_vld.
  - The beat is taken as slot 0: shadow0<=din, slot<=1.

Other rules:
- din_vld=0: no state or slot change, shadows hold, frame_vld=0.
- sync with din_vld=0 is ignored in both states.
- o0..o3 hold their last completed frame until the next completed frame.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- frame_vld and new o0..o3 are visible in the cycle after the edge that samples the slot-3 beat. Latency is 1 cycle from the last beat.
- Back-to-back frames at one beat per cycle produce frame_vld every 4th cycle, with no bubbles needed.
- sync_err is visible in the cycle after the misaligned beat.
- locked rises in the cycle after the first sync beat in IDLE and stays high until reset.
- {s1,s0} always shows the slot the next beat will fill.
- Throughput: one beat per clock; din_vld may be held high indefinitely.

## Configuration
DEMUX_ERRCNT_EN:
- Defined:
  - err_cnt port exists.
  - err_cnt increments by 1 on every sync_err pulse and saturates at 255.
  - err_cnt clears only on reset.
- Undefined:
  - err_cnt port and its counter are removed.
  - All other behaviour is identical.

## Test plan
- Reset then idle: hold rst_n=0 for 2 cycles with din_vld=1, sync=1, din=1 (W=1). Outputs stay 0, locked=0. After release, the first sync beat gives locked=1 the next cycle.
- Basic frame: W=4, beats 0xA(sync), 0xB, 0xC, 0xD on consecutive cycles. One cycle after the 0xD edge: o0..o3 = A,B,C,D, frame_vld=1 for exactly 1 cycle, {s1,s0}=0.
- Gapped input: same frame with din_vld=0 for 3 cycles between beats 1 and 2. Result matches the basic frame; frame_vld fires only after beat 3; {s1,s0} holds at 2 during the gap.
- Misaligned sync: after frame A..D, send 1,2 then 5(sync),6,7,8.
  - sync_err pulses once after the 5 beat.
  - No frame_vld for 1,2; o stays A..D.
  - Next frame gives o=5,6,7,8.
  - err_cnt=1 when DEMUX_ERRCNT_EN is defined.
- Continuous stream and saturation: 10 back-to-back frames with no sync after the first. frame_vld every 4 cycles with correct values. Then 300 misaligned syncs: err_cnt stops at 255.
- Reset mid-frame: assert rst_n=0 after beat 2 of a frame. o0..o3=0, locked=0, {s1,s0}=0. Beats without sync are then ignored until a sync beat arrives.

Source files
------------

// File: rtl/demux14_tdm.sv
// Receive side of the 4:1 TDM link: collects slot beats 0..3 into shadows and
// publishes a full frame with a one-cycle frame_vld. Optional DEMUX_ERRCNT_EN adds err_cnt.
module demux14_tdm #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_vld,
  input  logic         sync,
  output logic [W-1:0] o0,
  output logic [W-1:0] o1,
  output logic [W-1:0] o2,
  output logic [W-1:0] o3,
  output logic         s1,
  output logic         s0,
  output logic         frame_vld,
  output logic         sync_err,
  output logic         locked
`ifdef DEMUX_ERRCNT_EN
  ,
  output logic [7:0]   err_cnt
`endif
);

  // Handshake: a beat is transferred on any rising edge where din_vld=1; there
  // is no backpressure, so din_vld may stay high every cycle.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t       state, state_nxt;
  logic [1:0]   slot, slot_nxt;
  logic [W-1:0] sh0, sh1, sh2;

  logic         take_slot0;
  logic         take_sh1;
  logic         take_sh2;
  logic         frame_done;
  logic         mis_sync;

  // State and slot register; locked is simply the registered RUN state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      slot      <= 2'd0;
      sh0       <= '0;
      sh1       <= '0;
      sh2       <= '0;
      o0        <= '0;
      o1        <= '0;
      o2        <= '0;
      o3        <= '0;
      frame_vld <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      slot      <= slot_nxt;
      frame_vld <= frame_done;
      sync_err  <= mis_sync;
      if (take_slot0) sh0 <= din;
      if (take_sh1)   sh1 <= din;
      if (take_sh2)   sh2 <= din;
      if (frame_done) begin
        o0 <= sh0;
        o1 <= sh1;
        o2 <= sh2;
        o3 <= din;
      end
    end
  end

  // Next-state and next-slot decode.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    if (din_vld) begin
      case (state)
        IDLE: begin
          if (sync) begin
            state_nxt = RUN;
            slot_nxt  = 2'd1;
          end
        end
        RUN: begin
          // A sync anywhere but slot 0 restarts the frame at this beat.
          if (sync && slot != 2'd0) slot_nxt = 2'd1;
          else                      slot_nxt = slot + 2'd1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Per-beat actions: shadow writes, frame completion and misalignment flag.
  always_comb begin
    take_slot0 = 1'b0;
    take_sh1   = 1'b0;
    take_sh2   = 1'b0;
    frame_done = 1'b0;
    mis_sync   = 1'b0;
    if (din_vld) begin
      if (state == IDLE) begin
        take_slot0 = sync;
      end else if (sync && slot != 2'd0) begin
        mis_sync   = 1'b1;
        take_slot0 = 1'b1;
      end else begin
        take_slot0 = (slot == 2'd0);
        take_sh1   = (slot == 2'd1);
        take_sh2   = (slot == 2'd2);
        frame_done = (slot == 2'd3);
      end
    end
  end

  assign locked = (state == RUN);
  assign s1     = slot[1];
  assign s0     = slot[0];

`ifdef DEMUX_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                         err_cnt <= 8'd0;
    else if (mis_sync && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_demux14_tdm.sv
// Directed bench for demux14_tdm (W=4): reset, framing, gaps, misaligned sync,
// continuous stream, error saturation and mid-frame reset.
module tb_demux14_tdm;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_vld;
  logic         sync;
  logic [W-1:0] o0, o1, o2, o3;
  logic         s1, s0;
  logic         frame_vld;
  logic         sync_err;
  logic         locked;
`ifdef DEMUX_ERRCNT_EN
  logic [7:0]   err_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux14_tdm #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
    .sync      (sync),
    .o0        (o0),
    .o1        (o1),
    .o2        (o2),
    .o3        (o3),
    .s1        (s1),
    .s0        (s0),
    .frame_vld (frame_vld),
    .sync_err  (sync_err),
    .locked    (locked)
`ifdef DEMUX_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, let the edge sample them, then settle.
  task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
    din_vld = v;
    sync    = s;
    din     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_o(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                       input logic [W-1:0] e2, input logic [W-1:0] e3);
    chk({tag, ".o0"}, 32'(o0), 32'(e0));
    chk({tag, ".o1"}, 32'(o1), 32'(e1));
    chk({tag, ".o2"}, 32'(o2), 32'(e2));
    chk({tag, ".o3"}, 32'(o3), 32'(e3));
  endtask

  task automatic chk_ctl(input string tag, input logic fv, input logic se,
                         input logic lk, input logic [1:0] sl);
    chk({tag, ".frame_vld"}, 32'(frame_vld), 32'(fv));
    chk({tag, ".sync_err"},  32'(sync_err),  32'(se));
    chk({tag, ".locked"},    32'(locked),    32'(lk));
    chk({tag, ".slot"},      32'({s1, s0}),  32'(sl));
  endtask

  initial begin
    logic [W-1:0] e [4];
    int errs;

    // Reset held for two cycles with a sync beat present: nothing may happen.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 4'h1);
    drive(1'b1, 1'b1, 4'h1);
    chk_o("rst", 4'h0, 4'h0, 4'h0, 4'h0);
    chk_ctl("rst", 1'b0, 1'b0, 1'b0, 2'd0);
`ifdef DEMUX_ERRCNT_EN
    chk("rst.err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst_n = 1'b1;

    // IDLE ignores beats without sync.
    drive(1'b1, 1'b0, 4'h7);
    chk_ctl("idle_nosync", 1'b0, 1'b0, 1'b0, 2'd0);

    // Basic frame A,B,C,D.
    drive(1'b1, 1'b1, 4'hA);
    chk_ctl("basic.b0", 1'b0, 1'b0, 1'b1, 2'd1);
    drive(1'b1, 1'b0, 4'hB);
    drive(1'b1, 1'b0, 4'hC);
    chk_ctl("basic.b2", 1'b0, 1'b0, 1'b1, 2'd3);
    chk_o("basic.pre", 4'h0, 4'h0, 4'h0, 4'h0);
    drive(1'b1, 1'b0, 4'hD);
    chk_ctl("basic.b3", 1'b1, 1'b0, 1'b1, 2'd0);
    chk_o("basic", 4'hA, 4'hB, 4'hC, 4'hD);
    drive(1'b0, 1'b0, 4'h0);
    chk_ctl("basic.after", 1'b0, 1'b0, 1'b1, 2'd0);
    chk_o("basic.hold", 4'hA, 4'hB, 4'hC, 4'hD);

    // Gapped frame 3,4,<gap x3 with stray sync>,5,6.
    drive(1'b1, 1'b1, 4'h3);
    drive(1'b1, 1'b0, 4'h4);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 4'hF);
      chk_ctl("gap", 1'b0, 1'b0, 1'b1, 2'd2);
    end
    chk_o("gap.hold", 4'hA, 4'hB, 4'hC, 4'hD);
    drive(1'b1, 1'b0, 4'h5);
    chk_ctl("gap.b2", 1'b0, 1'b0, 1'b1, 2'd3);
    drive(1'b1, 1'b0, 4'h6);
    chk_ctl("gap.b3", 1'b1, 1'b0, 1'b1, 2'd0);
    chk_o("gap", 4'h3, 4'h4, 4'h5, 4'h6);

    // Frame A..D, then misaligned: 1,2,5(sync),6,7,8.
    drive(1'b1, 1'b1, 4'hA);
    drive(1'b1, 1'b0, 4'hB);
    drive(1'b1, 1'b0, 4'hC);
    drive(1'b1, 1'b0, 4'hD);
    chk_o("mis.ref", 4'hA, 4'hB, 4'hC, 4'hD);
    drive(1'b1, 1'b0, 4'h1);
    chk_ctl("mis.b1", 1'b0, 1'b0, 1'b1, 2'd1);
    drive(1'b1, 1'b0, 4'h2);
    drive(1'b1, 1'b1, 4'h5);
    chk_ctl("mis.sync", 1'b0, 1'b1, 1'b1, 2'd1);
    chk_o("mis.hold", 4'hA, 4'hB, 4'hC, 4'hD);
    drive(1'b1, 1'b0, 4'h6);
    chk_ctl("mis.b6", 1'b0, 1'b0, 1'b1, 2'd2);
    drive(1'b1, 1'b0, 4'h7);
    drive(1'b1, 1'b0, 4'h8);
    chk_ctl("mis.frame", 1'b1, 1'b0, 1'b1, 2'd0);
    chk_o("mis", 4'h5, 4'h6, 4'h7, 4'h8);
`ifdef DEMUX_ERRCNT_EN
    chk("mis.err_cnt", 32'(err_cnt), 32'd1);
`endif

    // Ten back-to-back frames, sync only on the first beat.
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < 4; k++) begin
        e[k] = W'((f * 3 + k * 5 + 1) % 16);
        drive(1'b1, (f == 0 && k == 0), e[k]);
        if (k == 3) begin
          chk_ctl("stream.end", 1'b1, 1'b0, 1'b1, 2'd0);
          chk_o("stream", e[0], e[1], e[2], e[3]);
        end else begin
          chk("stream.mid.frame_vld", 32'(frame_vld), 32'd0);
        end
      end
    end

    // 301 sync beats: the first is a normal slot-0 sync, the next 300 are misaligned.
    drive(1'b1, 1'b1, 4'h9);
    chk("sat.first.sync_err", 32'(sync_err), 32'd0);
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, 4'h9);
      if (sync_err === 1'b1) errs++;
    end
    chk("sat.pulses", 32'(errs), 32'd300);
    chk_o("sat.hold", e[0], e[1], e[2], e[3]);
`ifdef DEMUX_ERRCNT_EN
    chk("sat.err_cnt", 32'(err_cnt), 32'd255);
`endif

    // Reset after beat 2 of a frame.
    drive(1'b0, 1'b0, 4'h0);
    drive(1'b1, 1'b0, 4'h2);
    drive(1'b1, 1'b0, 4'h3);
    chk_ctl("mid.pre", 1'b0, 1'b0, 1'b1, 2'd3);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 4'h4);
    rst_n = 1'b1;
    chk_o("mid.rst", 4'h0, 4'h0, 4'h0, 4'h0);
    chk_ctl("mid.rst", 1'b0, 1'b0, 1'b0, 2'd0);
`ifdef DEMUX_ERRCNT_EN
    chk("mid.err_cnt", 32'(err_cnt), 32'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, W'(i + 12));
      chk_ctl("mid.ignore", 1'b0, 1'b0, 1'b0, 2'd0);
    end
    drive(1'b1, 1'b1, 4'hE);
    chk_ctl("mid.relock", 1'b0, 1'b0, 1'b1, 2'd1);
    drive(1'b1, 1'b0, 4'h1);
    drive(1'b1, 1'b0, 4'h2);
    drive(1'b1, 1'b0, 4'h3);
    chk_ctl("mid.frame", 1'b1, 1'b0, 1'b1, 2'd0);
    chk_o("mid.frame", 4'hE, 4'h1, 4'h2, 4'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
